exe_stage: RTL and testbench

- Execute stage of the 5-stage LoongArch pipeline, directly downstream of the decode stage.
- Latches the 168-bit decode bus, computes ALU, multiply and iterative divide results, and issues data-SRAM requests.
- Forwards a 76-bit bus to the memory stage.
- Exposes its valid and result bus for decode-stage hazard detection and forwarding.

---
 rtl/exe_stage.sv | 253 +++++++++++++++++++++++++
 tb/tb_exe_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage: latches the decode bus, computes ALU / multiply / iterative divide
// results, issues data-SRAM requests and forwards a 76-bit bus to the memory stage.
module exe_stage (
   input  logic         clk,
   input  logic         resetn,
   input  logic         ms_allowin,
   output logic         es_allowin,
   input  logic         ds_to_es_valid,
   input  logic [167:0] ds_to_es_bus,
   output logic         es_to_ms_valid,
   output logic [75:0]  es_to_ms_bus,
   output logic         out_es_valid,
   output logic         data_sram_en,
   output logic [3:0]   data_sram_we,
   output logic [31:0]  data_sram_addr,
   output logic [31:0]  data_sram_wdata
);

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   logic         es_valid_r;
   logic [167:0] bus_r;
   div_state_e   state_r;
   div_state_e   state_s;
   logic [4:0]   cnt_r;
   logic [31:0]  div_q_r;
   logic [31:0]  div_rem_r;
   logic [31:0]  div_b_r;
   logic         q_neg_r;
   logic         r_neg_r;

   logic [11:0]  alu_op_s;
   logic         src1_is_pc_s;
   logic [31:0]  pc_s;
   logic [31:0]  rj_value_s;
   logic         src2_is_imm_s;
   logic [31:0]  imm_s;
   logic [31:0]  rkd_value_s;
   logic         gr_we_s;
   logic [4:0]   dest_s;
   logic         res_from_mem_s;
   logic [3:0]   mem_we_s;
   logic [6:0]   divmul_op_s;
   logic [7:0]   ldst_op_s;

   assign {alu_op_s, src1_is_pc_s, pc_s, rj_value_s, src2_is_imm_s, imm_s,
           rkd_value_s, gr_we_s, dest_s, res_from_mem_s, mem_we_s,
           divmul_op_s, ldst_op_s} = bus_r;

   logic mul_w_s, mulh_w_s, mulh_wu_s, div_w_s, mod_w_s, div_wu_s, mod_wu_s;
   assign {mul_w_s, mulh_w_s, mulh_wu_s, div_w_s, mod_w_s, div_wu_s, mod_wu_s} = divmul_op_s;

   logic is_div_s;
   logic is_mul_s;
   logic is_load_s;
   logic is_store_s;
   logic es_ready_go_s;
   logic div_start_s;

   assign is_div_s   = div_w_s | mod_w_s | div_wu_s | mod_wu_s;
   assign is_mul_s   = mul_w_s | mulh_w_s | mulh_wu_s;
   assign is_load_s  = |ldst_op_s[7:3];
   assign is_store_s = |ldst_op_s[2:0];

   assign es_ready_go_s  = (es_valid_r & is_div_s) ? (state_r == DIV_DONE) : 1'b1;
   assign es_allowin     = ~es_valid_r | (es_ready_go_s & ms_allowin);
   assign es_to_ms_valid = es_valid_r & es_ready_go_s;
   assign out_es_valid   = es_valid_r;
   assign div_start_s    = es_valid_r & is_div_s & (state_r == DIV_IDLE);

   // Pipeline valid bit and decode-bus latch
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         es_valid_r <= 1'b0;
         bus_r      <= 168'd0;
      end else if (es_allowin) begin
         es_valid_r <= ds_to_es_valid;
         if (ds_to_es_valid) begin
            bus_r <= ds_to_es_bus;
         end
      end
   end

   // Operand selection and ALU
   logic [31:0] src1_s;
   logic [31:0] src2_s;
   logic [31:0] add_res_s;
   logic [31:0] sub_res_s;
   logic [31:0] slt_res_s;
   logic [31:0] sltu_res_s;
   logic [31:0] sra_res_s;
   logic [31:0] alu_res_s;

   assign src1_s     = src1_is_pc_s  ? pc_s  : rj_value_s;
   assign src2_s     = src2_is_imm_s ? imm_s : rkd_value_s;
   assign add_res_s  = src1_s + src2_s;
   assign sub_res_s  = src1_s - src2_s;
   assign slt_res_s  = {31'd0, ($signed(src1_s) < $signed(src2_s))};
   assign sltu_res_s = {31'd0, (src1_s < src2_s)};
   assign sra_res_s  = $signed(src1_s) >>> src2_s[4:0];

   assign alu_res_s = ({32{alu_op_s[0]}}  & add_res_s)
                    | ({32{alu_op_s[1]}}  & sub_res_s)
                    | ({32{alu_op_s[2]}}  & slt_res_s)
                    | ({32{alu_op_s[3]}}  & sltu_res_s)
                    | ({32{alu_op_s[4]}}  & (src1_s & src2_s))
                    | ({32{alu_op_s[5]}}  & ~(src1_s | src2_s))
                    | ({32{alu_op_s[6]}}  & (src1_s | src2_s))
                    | ({32{alu_op_s[7]}}  & (src1_s ^ src2_s))
                    | ({32{alu_op_s[8]}}  & (src1_s << src2_s[4:0]))
                    | ({32{alu_op_s[9]}}  & (src1_s >> src2_s[4:0]))
                    | ({32{alu_op_s[10]}} & sra_res_s)
                    | ({32{alu_op_s[11]}} & src2_s);

   // Sign-extend to 64 bits only for the signed high-word form; the low word is sign-agnostic
   logic [63:0] mul_a_s;
   logic [63:0] mul_b_s;
   logic [63:0] mul_prod_s;
   logic [31:0] mul_res_s;

   assign mul_a_s    = {{32{mulh_w_s & src1_s[31]}}, src1_s};
   assign mul_b_s    = {{32{mulh_w_s & src2_s[31]}}, src2_s};
   assign mul_prod_s = mul_a_s * mul_b_s;
   assign mul_res_s  = mul_w_s ? mul_prod_s[31:0] : mul_prod_s[63:32];

   // Divider operand magnitudes and one restoring step
   logic        div_signed_s;
   logic [31:0] abs_a_s;
   logic [31:0] abs_b_s;
   logic [32:0] rem_shift_s;
   logic        rem_ge_s;
   logic [31:0] rem_sub_s;

   assign div_signed_s = div_w_s | mod_w_s;
   assign abs_a_s      = (div_signed_s & rj_value_s[31])  ? (32'd0 - rj_value_s)  : rj_value_s;
   assign abs_b_s      = (div_signed_s & rkd_value_s[31]) ? (32'd0 - rkd_value_s) : rkd_value_s;
   assign rem_shift_s  = {div_rem_r, div_q_r[31]};
   assign rem_ge_s     = (rem_shift_s >= {1'b0, div_b_r});
   assign rem_sub_s    = rem_shift_s[31:0] - div_b_r;

   // Divider state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= DIV_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Divider next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         DIV_IDLE: begin
            if (div_start_s) state_s = DIV_BUSY;
            else             state_s = DIV_IDLE;
         end
         DIV_BUSY: begin
            if (cnt_r == 5'd31) state_s = DIV_DONE;
            else                state_s = DIV_BUSY;
         end
         DIV_DONE: begin
            if (es_valid_r & ms_allowin) state_s = DIV_IDLE;
            else                         state_s = DIV_DONE;
         end
         default: state_s = DIV_IDLE;
      endcase
   end

   // Divider datapath: latch operands on start, shift one quotient bit per busy cycle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_r     <= 5'd0;
         div_q_r   <= 32'd0;
         div_rem_r <= 32'd0;
         div_b_r   <= 32'd0;
         q_neg_r   <= 1'b0;
         r_neg_r   <= 1'b0;
      end else begin
         case (state_r)
            DIV_IDLE: begin
               if (div_start_s) begin
                  cnt_r     <= 5'd0;
                  div_q_r   <= abs_a_s;
                  div_rem_r <= 32'd0;
                  div_b_r   <= abs_b_s;
                  q_neg_r   <= div_signed_s & (rj_value_s[31] ^ rkd_value_s[31]);
                  r_neg_r   <= div_signed_s & rj_value_s[31];
               end
            end
            DIV_BUSY: begin
               cnt_r     <= cnt_r + 5'd1;
               div_q_r   <= {div_q_r[30:0], rem_ge_s};
               div_rem_r <= rem_ge_s ? rem_sub_s : rem_shift_s[31:0];
            end
            DIV_DONE: begin
               cnt_r <= cnt_r;
            end
            default: begin
               cnt_r <= 5'd0;
            end
         endcase
      end
   end

   logic [31:0] div_quot_s;
   logic [31:0] div_remd_s;
   logic [31:0] div_res_s;
   logic [31:0] es_result_s;

   assign div_quot_s = q_neg_r ? (32'd0 - div_q_r)   : div_q_r;
   assign div_remd_s = r_neg_r ? (32'd0 - div_rem_r) : div_rem_r;
   assign div_res_s  = (div_w_s | div_wu_s) ? div_quot_s : div_remd_s;

   // Final result select
   always_comb begin
      es_result_s = alu_res_s;
      if (is_div_s) begin
         es_result_s = div_res_s;
      end else if (is_mul_s) begin
         es_result_s = mul_res_s;
      end else begin
         es_result_s = alu_res_s;
      end
   end

   assign es_to_ms_bus = {ldst_op_s[7:3], res_from_mem_s, gr_we_s, dest_s, es_result_s, pc_s};

   // Data SRAM request; halfword stores align the lane shift to even bytes
   logic [1:0] we_shift_s;

   assign data_sram_en   = es_valid_r & es_ready_go_s & ms_allowin & (is_load_s | is_store_s);
   assign data_sram_addr = alu_res_s;
   assign we_shift_s     = ldst_op_s[1] ? {alu_res_s[1], 1'b0} : alu_res_s[1:0];
   assign data_sram_we   = (data_sram_en & is_store_s) ? (mem_we_s << we_shift_s) : 4'b0000;

   // Store data lane replication
   always_comb begin
      data_sram_wdata = rkd_value_s;
      if (ldst_op_s[2]) begin
         data_sram_wdata = {4{rkd_value_s[7:0]}};
      end else if (ldst_op_s[1]) begin
         data_sram_wdata = {2{rkd_value_s[15:0]}};
      end else begin
         data_sram_wdata = rkd_value_s;
      end
   end

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage: ALU, multiply, divide timing,
// store lane generation, stalled load request and mid-divide reset.
module tb_exe_stage;

   logic         clk;
   logic         resetn;
   logic         ms_allowin;
   logic         es_allowin;
   logic         ds_to_es_valid;
   logic [167:0] ds_to_es_bus;
   logic         es_to_ms_valid;
   logic [75:0]  es_to_ms_bus;
   logic         out_es_valid;
   logic         data_sram_en;
   logic [3:0]   data_sram_we;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   exe_stage dut (
      .clk             (clk),
      .resetn          (resetn),
      .ms_allowin      (ms_allowin),
      .es_allowin      (es_allowin),
      .ds_to_es_valid  (ds_to_es_valid),
      .ds_to_es_bus    (ds_to_es_bus),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .out_es_valid    (out_es_valid),
      .data_sram_en    (data_sram_en),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [6:0] DM_NONE  = 7'b0000000;
   localparam logic [6:0] DM_MULW  = 7'b1000000;
   localparam logic [6:0] DM_MULH  = 7'b0100000;
   localparam logic [6:0] DM_MULHU = 7'b0010000;
   localparam logic [6:0] DM_DIVW  = 7'b0001000;
   localparam logic [6:0] DM_MODW  = 7'b0000100;
   localparam logic [6:0] DM_DIVWU = 7'b0000010;
   localparam logic [6:0] DM_MODWU = 7'b0000001;

   function automatic logic [167:0] mk(input logic [11:0] alu_op, input logic s1pc,
                                       input logic [31:0] pc, input logic [31:0] rj,
                                       input logic s2imm, input logic [31:0] imm,
                                       input logic [31:0] rkd, input logic gr_we,
                                       input logic [4:0] dest, input logic rfm,
                                       input logic [3:0] mem_we, input logic [6:0] dm,
                                       input logic [7:0] ls);
      return {alu_op, s1pc, pc, rj, s2imm, imm, rkd, gr_we, dest, rfm, mem_we, dm, ls};
   endfunction

   task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [167:0] bus);
      ds_to_es_bus   = bus;
      ds_to_es_valid = 1'b1;
      @(posedge clk);
      #1;
      ds_to_es_valid = 1'b0;
      #1;
   endtask

   task automatic wait_done(output int stalls, output logic allowin_seen);
      stalls       = 0;
      allowin_seen = 1'b0;
      while (!es_to_ms_valid && stalls < 100) begin
         if (es_allowin) allowin_seen = 1'b1;
         stalls++;
         step();
      end
   endtask

   initial begin
      int   stalls;
      logic seen;
      int   pulses;

      resetn         = 1'b0;
      ms_allowin     = 1'b1;
      ds_to_es_valid = 1'b0;
      ds_to_es_bus   = 168'd0;
      #2;
      chk("rst_allowin",  {75'd0, es_allowin},     76'd1);
      chk("rst_ms_valid", {75'd0, es_to_ms_valid}, 76'd0);
      chk("rst_es_valid", {75'd0, out_es_valid},   76'd0);
      chk("rst_sram_en",  {75'd0, data_sram_en},   76'd0);
      chk("rst_sram_we",  {72'd0, data_sram_we},   76'd0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;

      // add.w 7 + 5
      issue(mk(12'h001, 1'b0, 32'h1C000000, 32'd7, 1'b0, 32'd0, 32'd5, 1'b1, 5'd3, 1'b0,
               4'b0000, DM_NONE, 8'h00));
      chk("add_result",   {44'd0, es_to_ms_bus[63:32]}, 76'd12);
      chk("add_valid",    {75'd0, es_to_ms_valid},      76'd1);
      chk("add_sram_en",  {75'd0, data_sram_en},        76'd0);
      chk("add_pc",       {44'd0, es_to_ms_bus[31:0]},  {44'd0, 32'h1C000000});
      chk("add_gr_dest",  {70'd0, es_to_ms_bus[69:64]}, {70'd0, 6'b100011});

      issue(mk(12'h002, 1'b0, 32'd0, 32'd5, 1'b0, 32'd0, 32'd7, 1'b1, 5'd1, 1'b0, 4'd0, DM_NONE, 8'h00));
      chk("sub_result",  {44'd0, es_to_ms_bus[63:32]}, {44'd0, 32'hFFFFFFFE});
      issue(mk(12'h004, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd1, 1'b1, 5'd1, 1'b0, 4'd0, DM_NONE, 8'h00));
      chk("slt_result",  {44'd0, es_to_ms_bus[63:32]}, 76'd1);
      issue(mk(12'h008, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd1, 1'b1, 5'd1, 1'b0, 4'd0, DM_NONE, 8'h00));
      chk("sltu_result", {44'd0, es_to_ms_bus[63:32]}, 76'd0);
      issue(mk(12'h020, 1'b0, 32'd0, 32'h0F0F0F0F, 1'b0, 32'd0, 32'h00FF00FF, 1'b1, 5'd1, 1'b0, 4'd0, DM_NONE, 8'h00));
      chk("nor_result",  {44'd0, es_to_ms_bus[63:32]}, {44'd0, 32'hF000F000});
      issue(mk(12'h400, 1'b0, 32'd0, 32'h80000000, 1'b1, 32'd4, 32'd0, 1'b1, 5'd1, 1'b0, 4'd0, DM_NONE, 8'h00));
      chk("sra_result",  {44'd0, es_to_ms_bus[63:32]}, {44'd0, 32'hF8000000});
      issue(mk(12'h200, 1'b0, 32'd0, 32'h80000000, 1'b1, 32'd4, 32'd0, 1'b1, 5'd1, 1'b0, 4'd0, DM_NONE, 8'h00));
      chk("srl_result",  {44'd0, es_to_ms_bus[63:32]}, {44'd0, 32'h08000000});
      issue(mk(12'h800, 1'b0, 32'd0, 32'd0, 1'b1, 32'h12345000, 32'd0, 1'b1, 5'd1, 1'b0, 4'd0, DM_NONE, 8'h00));
      chk("lu12i_result", {44'd0, es_to_ms_bus[63:32]}, {44'd0, 32'h12345000});
      issue(mk(12'h001, 1'b1, 32'h1C000100, 32'd0, 1'b1, 32'd8, 32'd0, 1'b1, 5'd1, 1'b0, 4'd0, DM_NONE, 8'h00));
      chk("pcadd_result", {44'd0, es_to_ms_bus[63:32]}, {44'd0, 32'h1C000108});

      // st.b to 0x1003 and st.h to 0x1002
      issue(mk(12'h001, 1'b0, 32'd0, 32'h1000, 1'b1, 32'd3, 32'h000000AB, 1'b0, 5'd0, 1'b0,
               4'b0001, DM_NONE, 8'b00000100));
      chk("stb_en",    {75'd0, data_sram_en},          76'd1);
      chk("stb_we",    {72'd0, data_sram_we},          {72'd0, 4'b1000});
      chk("stb_wdata", {44'd0, data_sram_wdata},       {44'd0, 32'hABABABAB});
      chk("stb_addr",  {44'd0, data_sram_addr},        {44'd0, 32'h00001003});
      chk("stb_gr_we", {75'd0, es_to_ms_bus[69]},      76'd0);
      issue(mk(12'h001, 1'b0, 32'd0, 32'h1000, 1'b1, 32'd2, 32'h00001234, 1'b0, 5'd0, 1'b0,
               4'b0011, DM_NONE, 8'b00000010));
      chk("sth_we",    {72'd0, data_sram_we},          {72'd0, 4'b1100});
      chk("sth_wdata", {44'd0, data_sram_wdata},       {44'd0, 32'h12341234});

      // div.w -7 / 2, then back-to-back mod.w
      issue(mk(12'h000, 1'b0, 32'd0, 32'hFFFFFFF9, 1'b0, 32'd0, 32'd2, 1'b1, 5'd4, 1'b0, 4'd0, DM_DIVW, 8'h00));
      wait_done(stalls, seen);
      chk("divw_stalls",  stalls, 76'd33);
      chk("divw_allowin", {75'd0, seen}, 76'd0);
      chk("divw_result",  {44'd0, es_to_ms_bus[63:32]}, {44'd0, 32'hFFFFFFFD});
      issue(mk(12'h000, 1'b0, 32'd0, 32'hFFFFFFF9, 1'b0, 32'd0, 32'd2, 1'b1, 5'd4, 1'b0, 4'd0, DM_MODW, 8'h00));
      wait_done(stalls, seen);
      chk("modw_stalls",  stalls, 76'd33);
      chk("modw_result",  {44'd0, es_to_ms_bus[63:32]}, {44'd0, 32'hFFFFFFFF});

      // multiplies on all-ones operands
      issue(mk(12'h000, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b1, 5'd5, 1'b0, 4'd0, DM_MULHU, 8'h00));
      chk("mulhwu_result", {44'd0, es_to_ms_bus[63:32]}, {44'd0, 32'hFFFFFFFE});
      chk("mulhwu_valid",  {75'd0, es_to_ms_valid}, 76'd1);
      issue(mk(12'h000, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b1, 5'd5, 1'b0, 4'd0, DM_MULH, 8'h00));
      chk("mulhw_result",  {44'd0, es_to_ms_bus[63:32]}, 76'd0);
      issue(mk(12'h000, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b1, 5'd5, 1'b0, 4'd0, DM_MULW, 8'h00));
      chk("mulw_result",   {44'd0, es_to_ms_bus[63:32]}, 76'd1);
      step();

      // ld.w stalled by the memory stage for three cycles
      ms_allowin = 1'b0;
      issue(mk(12'h001, 1'b0, 32'd0, 32'h2000, 1'b1, 32'd4, 32'd0, 1'b1, 5'd6, 1'b1, 4'd0, DM_NONE, 8'b00001000));
      pulses = 0;
      chk("ldw_stall_allowin", {75'd0, es_allowin}, 76'd0);
      for (int i = 0; i < 3; i++) begin
         if (data_sram_en) pulses++;
         step();
      end
      ms_allowin = 1'b1;
      #1;
      chk("ldw_en",       {75'd0, data_sram_en},          76'd1);
      chk("ldw_addr",     {44'd0, data_sram_addr},        {44'd0, 32'h00002004});
      chk("ldw_we",       {72'd0, data_sram_we},          76'd0);
      chk("ldw_ld_op",    {71'd0, es_to_ms_bus[75:71]},   {71'd0, 5'b00001});
      chk("ldw_from_mem", {75'd0, es_to_ms_bus[70]},      76'd1);
      if (data_sram_en) pulses++;
      @(posedge clk);
      #2;
      if (data_sram_en) pulses++;
      chk("ldw_pulses", pulses, 76'd1);

      // reset in the middle of a divide (busy counter = 10)
      issue(mk(12'h000, 1'b0, 32'd0, 32'd50, 1'b0, 32'd0, 32'd3, 1'b1, 5'd7, 1'b0, 4'd0, DM_DIVW, 8'h00));
      repeat (11) step();
      resetn = 1'b0;
      #1;
      chk("midrst_allowin",  {75'd0, es_allowin},     76'd1);
      chk("midrst_ms_valid", {75'd0, es_to_ms_valid}, 76'd0);
      chk("midrst_es_valid", {75'd0, out_es_valid},   76'd0);
      chk("midrst_sram_en",  {75'd0, data_sram_en},   76'd0);
      @(posedge clk);
      #1 resetn = 1'b1;
      #1;
      issue(mk(12'h000, 1'b0, 32'd0, 32'd100, 1'b0, 32'd0, 32'd7, 1'b1, 5'd8, 1'b0, 4'd0, DM_DIVWU, 8'h00));
      wait_done(stalls, seen);
      chk("divwu_stalls", stalls, 76'd33);
      chk("divwu_result", {44'd0, es_to_ms_bus[63:32]}, 76'd14);
      issue(mk(12'h000, 1'b0, 32'd0, 32'd100, 1'b0, 32'd0, 32'd7, 1'b1, 5'd8, 1'b0, 4'd0, DM_MODWU, 8'h00));
      wait_done(stalls, seen);
      chk("modwu_stalls", stalls, 76'd33);
      chk("modwu_result", {44'd0, es_to_ms_bus[63:32]}, 76'd2);
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
